// File: rtl/io_bridge_split_fta.sv
// Wide-to-narrow I/O bridge: splits one SWID-bit slave access into sequential
// MWID-bit master sub-transactions and reassembles read data into one response.
module io_bridge_split_fta #(
    parameter int SWID     = 128,
    parameter int MWID     = 32,
    parameter int ADR_W    = 32,
    parameter int TID_W    = 13,
    parameter int CHANNELS = 2,
    parameter int TIMEOUT  = 255,
    parameter int RTRY_MAX = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     s_cyc_i,
    input  logic                     s_stb_i,
    input  logic                     s_we_i,
    input  logic [TID_W-1:0]         s_tid_i,
    input  logic [ADR_W-1:0]         s_padr_i,
    input  logic [SWID/8-1:0]        s_sel_i,
    input  logic [SWID-1:0]          s_dat_i,
    output logic                     s_stall_o,
    output logic                     s_ack_o,
    output logic                     s_err_o,
    output logic [TID_W-1:0]         s_tid_o,
    output logic [SWID-1:0]          s_dat_o,
    output logic                     m_cyc_o,
    output logic                     m_stb_o,
    output logic                     m_we_o,
    output logic [ADR_W-1:0]         m_padr_o,
    output logic [MWID/8-1:0]        m_sel_o,
    output logic [MWID-1:0]          m_dat_o,
    output logic [TID_W-1:0]         m_tid_o,
    input  logic [CHANNELS-1:0]      ch_ack_i,
    input  logic [CHANNELS-1:0]      ch_err_i,
    input  logic [CHANNELS-1:0]      ch_rty_i,
    input  logic [CHANNELS*MWID-1:0] ch_dat_i
);
    localparam int R   = SWID / MWID;
    localparam int SB  = SWID / 8;
    localparam int MB  = MWID / 8;
    localparam int LW  = (R > 1) ? $clog2(R) : 1;
    localparam int MBW = (MB > 1) ? $clog2(MB) : 1;
    localparam int OFW = $clog2(SB);
    localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RW  = (RTRY_MAX > 0) ? $clog2(RTRY_MAX + 1) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, DONE} state_t;

    state_t               state_q, state_d;
    logic [TID_W-1:0]     tid_q, tid_d;
    logic [ADR_W-1:OFW]   padr_q, padr_d;
    logic [SB-1:0]        sel_q, sel_d;
    logic [SWID-1:0]      wdat_q, wdat_d;
    logic                 we_q, we_d;
    logic [R-1:0]         lanes_q, lanes_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic                 err_q, err_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [RW-1:0]        rty_q, rty_d;
    logic [SWID-1:0]      rbuf_q, rbuf_d;
    logic                 stall_q, stall_d;
    logic                 ack_q, ack_d;
    logic                 serr_q, serr_d;
    logic [TID_W-1:0]     stid_q, stid_d;
    logic [SWID-1:0]      sdat_q, sdat_d;
    logic                 mcyc_q, mcyc_d;
    logic [ADR_W-1:0]     mpadr_q, mpadr_d;
    logic [MB-1:0]        msel_q, msel_d;
    logic [MWID-1:0]      mdat_q, mdat_d;

    logic [R-1:0]         new_lanes;
    logic [LW-1:0]        lane_pick;
    logic [MB-1:0]        lane_sel;
    logic [MBW-1:0]       byte_pick;
    logic [OFW-1:0]       lane_off;
    logic                 hit;
    logic [CW-1:0]        hit_ch;
    logic                 lane_fin;
    logic                 lane_bad;
    logic                 unused_padr_lo;

    // The low address bits are always regenerated from the lane being issued.
    assign unused_padr_lo = ^s_padr_i[OFW-1:0];

    always_comb begin
        new_lanes = '0;
        for (int i = 0; i < R; i++) begin
            new_lanes[i] = |s_sel_i[i*MB +: MB];
        end
        lane_pick = '0;
        for (int i = R - 1; i >= 0; i--) begin
            if (lanes_q[i]) lane_pick = LW'(i);
        end
        lane_sel  = sel_q[lane_pick*MB +: MB];
        byte_pick = '0;
        for (int b = MB - 1; b >= 0; b--) begin
            if (lane_sel[b]) byte_pick = MBW'(b);
        end
        lane_off = OFW'(lane_pick) * OFW'(MB) + OFW'(byte_pick);
        // Lowest-index channel with any strobe owns the response this cycle.
        hit    = 1'b0;
        hit_ch = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (ch_ack_i[c] | ch_err_i[c] | ch_rty_i[c]) begin
                hit    = 1'b1;
                hit_ch = CW'(c);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        tid_d    = tid_q;
        padr_d   = padr_q;
        sel_d    = sel_q;
        wdat_d   = wdat_q;
        we_d     = we_q;
        lanes_d  = lanes_q;
        lane_d   = lane_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        rty_d    = rty_q;
        rbuf_d   = rbuf_q;
        stall_d  = stall_q;
        ack_d    = 1'b0;
        serr_d   = 1'b0;
        stid_d   = stid_q;
        sdat_d   = sdat_q;
        mcyc_d   = mcyc_q;
        mpadr_d  = mpadr_q;
        msel_d   = msel_q;
        mdat_d   = mdat_q;
        lane_fin = 1'b0;
        lane_bad = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (s_cyc_i && s_stb_i) begin
                    tid_d   = s_tid_i;
                    padr_d  = s_padr_i[ADR_W-1:OFW];
                    sel_d   = s_sel_i;
                    wdat_d  = s_dat_i;
                    we_d    = s_we_i;
                    lanes_d = new_lanes;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                    rty_d   = '0;
                    rbuf_d  = '0;
                    stall_d = 1'b1;
                    state_d = (s_sel_i == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                lane_d  = lane_pick;
                mcyc_d  = 1'b1;
                msel_d  = lane_sel;
                mdat_d  = wdat_q[lane_pick*MWID +: MWID];
                mpadr_d = {padr_q, lane_off};
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (hit) begin
                    if (ch_err_i[hit_ch]) begin
                        lane_fin = 1'b1;
                        lane_bad = 1'b1;
                    end else if (ch_ack_i[hit_ch]) begin
                        lane_fin = 1'b1;
                        if (!we_q) rbuf_d[lane_q*MWID +: MWID] = ch_dat_i[hit_ch*MWID +: MWID];
                    end else if (rty_q == RW'(RTRY_MAX)) begin
                        lane_fin = 1'b1;
                        lane_bad = 1'b1;
                    end else begin
                        rty_d   = rty_q + RW'(1);
                        tmo_d   = '0;
                        mcyc_d  = 1'b0;
                        state_d = GAP;
                    end
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    lane_fin = 1'b1;
                    lane_bad = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
                // A finished lane (good or faulted) is retired and never reissued.
                if (lane_fin) begin
                    lanes_d[lane_q] = 1'b0;
                    err_d   = err_q | lane_bad;
                    rty_d   = '0;
                    tmo_d   = '0;
                    mcyc_d  = 1'b0;
                    state_d = (lanes_d == '0) ? DONE : GAP;
                end
            end
            GAP: begin
                state_d = ISSUE;
            end
            DONE: begin
                ack_d   = ~err_q;
                serr_d  = err_q;
                stid_d  = tid_q;
                sdat_d  = rbuf_q;
                stall_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            tid_q   <= '0;
            padr_q  <= '0;
            sel_q   <= '0;
            wdat_q  <= '0;
            we_q    <= 1'b0;
            lanes_q <= '0;
            lane_q  <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            rty_q   <= '0;
            rbuf_q  <= '0;
            stall_q <= 1'b0;
            ack_q   <= 1'b0;
            serr_q  <= 1'b0;
            stid_q  <= '0;
            sdat_q  <= '0;
            mcyc_q  <= 1'b0;
            mpadr_q <= '1;
            msel_q  <= '0;
            mdat_q  <= '0;
        end else begin
            state_q <= state_d;
            tid_q   <= tid_d;
            padr_q  <= padr_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            we_q    <= we_d;
            lanes_q <= lanes_d;
            lane_q  <= lane_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            rty_q   <= rty_d;
            rbuf_q  <= rbuf_d;
            stall_q <= stall_d;
            ack_q   <= ack_d;
            serr_q  <= serr_d;
            stid_q  <= stid_d;
            sdat_q  <= sdat_d;
            mcyc_q  <= mcyc_d;
            mpadr_q <= mpadr_d;
            msel_q  <= msel_d;
            mdat_q  <= mdat_d;
        end
    end

    assign s_stall_o = stall_q;
    assign s_ack_o   = ack_q;
    assign s_err_o   = serr_q;
    assign s_tid_o   = stid_q;
    assign s_dat_o   = sdat_q;
    assign m_cyc_o   = mcyc_q;
    assign m_stb_o   = mcyc_q;
    assign m_we_o    = we_q;
    assign m_tid_o   = tid_q;
    assign m_padr_o  = mpadr_q;
    assign m_sel_o   = msel_q;
    assign m_dat_o   = mdat_q;

endmodule

// File: tb/tb_io_bridge_split_fta.sv
// Directed self-checking bench for io_bridge_split_fta with hand-computed
// expectations for reads, splits, retries, timeout, priority and reset.
module tb_io_bridge_split_fta;
    localparam int SWID = 128, MWID = 32, ADR_W = 32, TID_W = 13, CHANNELS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_ni = 1'b0;
    logic                     s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
    logic [TID_W-1:0]         s_tid = '0;
    logic [ADR_W-1:0]         s_padr = '0;
    logic [SWID/8-1:0]        s_sel = '0;
    logic [SWID-1:0]          s_dat_in = '0;
    logic                     s_stall_o, s_ack_o, s_err_o;
    logic [TID_W-1:0]         s_tid_o;
    logic [SWID-1:0]          s_dat_o;
    logic                     m_cyc_o, m_stb_o, m_we_o;
    logic [ADR_W-1:0]         m_padr_o;
    logic [MWID/8-1:0]        m_sel_o;
    logic [MWID-1:0]          m_dat_o;
    logic [TID_W-1:0]         m_tid_o;
    logic [CHANNELS-1:0]      ch_ack = '0, ch_err = '0, ch_rty = '0;
    logic [CHANNELS*MWID-1:0] ch_dat = '0;

    int checks = 0;
    int fails  = 0;

    io_bridge_split_fta dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_we_i(s_we), .s_tid_i(s_tid),
        .s_padr_i(s_padr), .s_sel_i(s_sel), .s_dat_i(s_dat_in),
        .s_stall_o(s_stall_o), .s_ack_o(s_ack_o), .s_err_o(s_err_o),
        .s_tid_o(s_tid_o), .s_dat_o(s_dat_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
        .m_padr_o(m_padr_o), .m_sel_o(m_sel_o), .m_dat_o(m_dat_o), .m_tid_o(m_tid_o),
        .ch_ack_i(ch_ack), .ch_err_i(ch_err), .ch_rty_i(ch_rty), .ch_dat_i(ch_dat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic we, input logic [TID_W-1:0] tid, input logic [ADR_W-1:0] padr,
                            input logic [SWID/8-1:0] sel, input logic [SWID-1:0] dat);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_tid = tid; s_padr = padr; s_sel = sel; s_dat_in = dat;
        tick();
        s_cyc = 1'b0; s_stb = 1'b0;
    endtask

    task automatic wait_issue(output int waited);
        waited = 0;
        while (!m_cyc_o && waited < 20) begin
            tick();
            waited++;
        end
    endtask

    // kind: 0 = ack, 1 = err, 2 = rty
    task automatic respond(input int kind, input int ch, input logic [MWID-1:0] data);
        ch_dat = '0;
        ch_dat[ch*MWID +: MWID] = data;
        if (kind == 0) ch_ack[ch] = 1'b1;
        else if (kind == 1) ch_err[ch] = 1'b1;
        else ch_rty[ch] = 1'b1;
        tick();
        ch_ack = '0; ch_err = '0; ch_rty = '0; ch_dat = '0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick(); tick();
        checks++; if (m_cyc_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_mcyc: got %b expected 0", m_cyc_o); end
        checks++; if (m_padr_o !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL reset_mpadr: got %h expected ffffffff", m_padr_o); end
        checks++; if ({s_stall_o, s_ack_o, s_err_o, m_stb_o, m_we_o} !== 5'b0) begin fails++; $display("[TB] FAIL reset_flags: got %b expected 00000", {s_stall_o, s_ack_o, s_err_o, m_stb_o, m_we_o}); end
        checks++; if (s_dat_o !== '0 || m_sel_o !== '0 || m_dat_o !== '0) begin fails++; $display("[TB] FAIL reset_data: s_dat %h m_sel %h m_dat %h expected 0", s_dat_o, m_sel_o, m_dat_o); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int w;
        send_req(1'b0, 13'h0101, 32'h1000, 16'h0030, '0);
        checks++; if (m_cyc_o !== 1'b0) begin fails++; $display("[TB] FAIL rd_early_cyc: got %b expected 0", m_cyc_o); end
        checks++; if (s_stall_o !== 1'b1) begin fails++; $display("[TB] FAIL rd_stall: got %b expected 1", s_stall_o); end
        wait_issue(w);
        checks++; if (w != 1) begin fails++; $display("[TB] FAIL rd_issue_latency: got %0d expected 1", w); end
        checks++; if (m_padr_o !== 32'h1004) begin fails++; $display("[TB] FAIL rd_padr: got %h expected 00001004", m_padr_o); end
        checks++; if (m_sel_o !== 4'h3 || m_we_o !== 1'b0 || m_tid_o !== 13'h0101) begin fails++; $display("[TB] FAIL rd_fields: sel %h we %b tid %h expected 3 0 0101", m_sel_o, m_we_o, m_tid_o); end
        tick(); tick();
        checks++; if (m_cyc_o !== 1'b1 || m_stb_o !== 1'b1) begin fails++; $display("[TB] FAIL rd_hold: cyc %b stb %b expected 1 1", m_cyc_o, m_stb_o); end
        respond(0, 0, 32'hDEADBEEF);
        checks++; if (m_cyc_o !== 1'b0 || s_ack_o !== 1'b0) begin fails++; $display("[TB] FAIL rd_after_ack: cyc %b ack %b expected 0 0", m_cyc_o, s_ack_o); end
        tick();
        checks++; if (s_ack_o !== 1'b1 || s_err_o !== 1'b0) begin fails++; $display("[TB] FAIL rd_ack: ack %b err %b expected 1 0", s_ack_o, s_err_o); end
        checks++; if (s_dat_o !== {64'h0, 32'hDEADBEEF, 32'h0}) begin fails++; $display("[TB] FAIL rd_data: got %h expected %h", s_dat_o, {64'h0, 32'hDEADBEEF, 32'h0}); end
        checks++; if (s_tid_o !== 13'h0101) begin fails++; $display("[TB] FAIL rd_tid: got %h expected 0101", s_tid_o); end
        tick();
        checks++; if (s_ack_o !== 1'b0 || m_cyc_o !== 1'b0) begin fails++; $display("[TB] FAIL rd_pulse_end: ack %b cyc %b expected 0 0", s_ack_o, m_cyc_o); end
        checks++; if (s_dat_o !== {64'h0, 32'hDEADBEEF, 32'h0}) begin fails++; $display("[TB] FAIL rd_data_hold: got %h", s_dat_o); end
    endtask

    task automatic test_write_split();
        int w;
        logic [SWID-1:0] wd;
        wd = 128'h44443333_22221111_00009999_88887777;
        send_req(1'b1, 13'h0202, 32'h2000, 16'hFFFF, wd);
        for (int j = 0; j < 4; j++) begin
            wait_issue(w);
            checks++; if (w != ((j == 0) ? 1 : 2)) begin fails++; $display("[TB] FAIL wr_issue_latency lane %0d: got %0d expected %0d", j, w, (j == 0) ? 1 : 2); end
            checks++; if (m_padr_o !== 32'h2000 + 32'(j * 4)) begin fails++; $display("[TB] FAIL wr_padr lane %0d: got %h expected %h", j, m_padr_o, 32'h2000 + 32'(j * 4)); end
            checks++; if (m_dat_o !== wd[j*32 +: 32]) begin fails++; $display("[TB] FAIL wr_data lane %0d: got %h expected %h", j, m_dat_o, wd[j*32 +: 32]); end
            checks++; if (m_sel_o !== 4'hF || m_we_o !== 1'b1 || m_tid_o !== 13'h0202) begin fails++; $display("[TB] FAIL wr_fields lane %0d: sel %h we %b tid %h", j, m_sel_o, m_we_o, m_tid_o); end
            checks++; if (s_stall_o !== 1'b1) begin fails++; $display("[TB] FAIL wr_stall lane %0d: got %b expected 1", j, s_stall_o); end
            respond(0, j % 2, 32'hFFFF_FFFF);
            if (j < 3) begin
                checks++; if (s_ack_o !== 1'b0 || s_stall_o !== 1'b1) begin fails++; $display("[TB] FAIL wr_mid lane %0d: ack %b stall %b expected 0 1", j, s_ack_o, s_stall_o); end
            end
        end
        tick();
        checks++; if (s_ack_o !== 1'b1 || s_err_o !== 1'b0) begin fails++; $display("[TB] FAIL wr_ack: ack %b err %b expected 1 0", s_ack_o, s_err_o); end
        checks++; if (s_dat_o !== '0) begin fails++; $display("[TB] FAIL wr_sdat: got %h expected 0", s_dat_o); end
        tick();
    endtask

    task automatic test_retry();
        int w;
        send_req(1'b0, 13'h0303, 32'h3000, 16'h00F0, '0);
        for (int r = 0; r < 4; r++) begin
            wait_issue(w);
            if (r > 0) begin
                checks++; if (w != 2) begin fails++; $display("[TB] FAIL rty_gap issue %0d: got %0d expected 2", r, w); end
            end
            checks++; if (m_cyc_o !== 1'b1 || m_padr_o !== 32'h3004) begin fails++; $display("[TB] FAIL rty_issue %0d: cyc %b padr %h expected 1 00003004", r, m_cyc_o, m_padr_o); end
            if (r < 3) respond(2, 0, 32'h0);
            else respond(0, 1, 32'hCAFEF00D);
        end
        tick();
        checks++; if (s_ack_o !== 1'b1 || s_err_o !== 1'b0) begin fails++; $display("[TB] FAIL rty3_ack: ack %b err %b expected 1 0", s_ack_o, s_err_o); end
        checks++; if (s_dat_o !== {64'h0, 32'hCAFEF00D, 32'h0}) begin fails++; $display("[TB] FAIL rty3_data: got %h", s_dat_o); end
        tick();
        send_req(1'b0, 13'h0304, 32'h3000, 16'h00F0, '0);
        for (int r = 0; r < 4; r++) begin
            wait_issue(w);
            checks++; if (m_cyc_o !== 1'b1) begin fails++; $display("[TB] FAIL rty4_issue %0d: got %b expected 1", r, m_cyc_o); end
            respond(2, 0, 32'h0);
        end
        checks++; if (m_cyc_o !== 1'b0) begin fails++; $display("[TB] FAIL rty4_drop: got %b expected 0", m_cyc_o); end
        tick();
        checks++; if (s_err_o !== 1'b1 || s_ack_o !== 1'b0) begin fails++; $display("[TB] FAIL rty4_err: err %b ack %b expected 1 0", s_err_o, s_ack_o); end
        checks++; if (s_dat_o !== '0 || s_tid_o !== 13'h0304) begin fails++; $display("[TB] FAIL rty4_resp: dat %h tid %h expected 0 0304", s_dat_o, s_tid_o); end
        tick();
        checks++; if (m_cyc_o !== 1'b0) begin fails++; $display("[TB] FAIL rty4_no_fifth: got %b expected 0", m_cyc_o); end
    endtask

    task automatic test_timeout();
        int w;
        int cnt;
        send_req(1'b0, 13'h0ABC, 32'h5000, 16'h000F, '0);
        wait_issue(w);
        checks++; if (m_cyc_o !== 1'b1) begin fails++; $display("[TB] FAIL tmo_issue: got %b expected 1", m_cyc_o); end
        cnt = 0;
        while (m_cyc_o && cnt < 300) begin
            tick();
            cnt++;
        end
        checks++; if (cnt != 256) begin fails++; $display("[TB] FAIL tmo_cycles: got %0d expected 256", cnt); end
        tick();
        checks++; if (s_err_o !== 1'b1 || s_ack_o !== 1'b0) begin fails++; $display("[TB] FAIL tmo_err: err %b ack %b expected 1 0", s_err_o, s_ack_o); end
        checks++; if (s_tid_o !== 13'h0ABC) begin fails++; $display("[TB] FAIL tmo_tid: got %h expected 0abc", s_tid_o); end
        tick();
    endtask

    task automatic test_priority();
        int w;
        send_req(1'b0, 13'h0606, 32'h6000, 16'h00FF, '0);
        wait_issue(w);
        checks++; if (m_padr_o !== 32'h6000) begin fails++; $display("[TB] FAIL pri_padr0: got %h expected 00006000", m_padr_o); end
        ch_ack = 2'b11;
        ch_dat = {32'hBBBBBBBB, 32'hAAAAAAAA};
        tick();
        ch_ack = '0; ch_dat = '0;
        wait_issue(w);
        checks++; if (w != 2 || m_padr_o !== 32'h6004) begin fails++; $display("[TB] FAIL pri_lane1: wait %0d padr %h expected 2 00006004", w, m_padr_o); end
        respond(0, 1, 32'h12345678);
        tick();
        checks++; if (s_ack_o !== 1'b1) begin fails++; $display("[TB] FAIL pri_ack: got %b expected 1", s_ack_o); end
        checks++; if (s_dat_o !== {64'h0, 32'h12345678, 32'hAAAAAAAA}) begin fails++; $display("[TB] FAIL pri_data: got %h expected %h", s_dat_o, {64'h0, 32'h12345678, 32'hAAAAAAAA}); end
        tick();
    endtask

    task automatic test_zero_sel();
        send_req(1'b0, 13'h0707, 32'h7000, 16'h0000, '0);
        checks++; if (m_cyc_o !== 1'b0 || s_stall_o !== 1'b1) begin fails++; $display("[TB] FAIL zs_accept: cyc %b stall %b expected 0 1", m_cyc_o, s_stall_o); end
        tick();
        checks++; if (s_ack_o !== 1'b1 || m_cyc_o !== 1'b0) begin fails++; $display("[TB] FAIL zs_ack: ack %b cyc %b expected 1 0", s_ack_o, m_cyc_o); end
        checks++; if (s_dat_o !== '0 || s_tid_o !== 13'h0707) begin fails++; $display("[TB] FAIL zs_resp: dat %h tid %h expected 0 0707", s_dat_o, s_tid_o); end
        tick();
        checks++; if (s_ack_o !== 1'b0 || m_cyc_o !== 1'b0 || s_stall_o !== 1'b0) begin fails++; $display("[TB] FAIL zs_after: ack %b cyc %b stall %b expected 0 0 0", s_ack_o, m_cyc_o, s_stall_o); end
    endtask

    task automatic test_reset_mid_split();
        int w;
        logic seen;
        send_req(1'b1, 13'h0808, 32'h8000, 16'hFFFF, 128'h1);
        for (int j = 0; j < 2; j++) begin
            wait_issue(w);
            respond(0, 0, 32'h0);
        end
        wait_issue(w);
        checks++; if (m_padr_o !== 32'h8008) begin fails++; $display("[TB] FAIL rst_lane2: got %h expected 00008008", m_padr_o); end
        tick();
        rst_ni = 1'b0;
        tick();
        checks++; if (m_cyc_o !== 1'b0 || m_padr_o !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL rst_mid: cyc %b padr %h expected 0 ffffffff", m_cyc_o, m_padr_o); end
        checks++; if (s_ack_o !== 1'b0 || s_err_o !== 1'b0 || s_stall_o !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_slave: ack %b err %b stall %b expected 0 0 0", s_ack_o, s_err_o, s_stall_o); end
        rst_ni = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (s_ack_o || s_err_o || m_cyc_o) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("[TB] FAIL rst_quiet: got %b expected 0", seen); end
        send_req(1'b0, 13'h0909, 32'h9000, 16'h0F00, '0);
        wait_issue(w);
        checks++; if (w != 1 || m_padr_o !== 32'h9008) begin fails++; $display("[TB] FAIL rst_new_issue: wait %0d padr %h expected 1 00009008", w, m_padr_o); end
        respond(0, 0, 32'h0BADCAFE);
        tick();
        checks++; if (s_ack_o !== 1'b1 || s_tid_o !== 13'h0909) begin fails++; $display("[TB] FAIL rst_new_ack: ack %b tid %h expected 1 0909", s_ack_o, s_tid_o); end
        checks++; if (s_dat_o !== {32'h0, 32'h0BADCAFE, 64'h0}) begin fails++; $display("[TB] FAIL rst_new_data: got %h", s_dat_o); end
        tick();
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_single_read();
        test_write_split();
        test_retry();
        test_timeout();
        test_priority();
        test_zero_sel();
        test_reset_mid_split();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
